// File: rtl/seq_restoring_divider_if.sv
// Handshake and operand/result bundle for the sequential restoring divider.
// The master issues operands and start; the slave returns results and status.
interface seq_restoring_divider_if;
    logic       start;
    logic [7:0] dividend;
    logic [7:0] divisor;
    logic [7:0] quotient;
    logic [7:0] remainder;
    logic       busy;
    logic       done;
    logic       div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  quotient, remainder, busy, done, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output quotient, remainder, busy, done, div_by_zero
    );
endinterface

// File: rtl/seq_restoring_divider.sv
// Sequential unsigned restoring divider: one quotient bit per clock, with the
// trial subtraction done by an 8-bit ripple-borrow subtractor.

module ripple_subtractor (
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic [7:0] diff,
    output logic       bout
);
    logic [8:0] borrow;

    assign borrow[0] = 1'b0;

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_bit
            assign diff[gi]       = a[gi] ^ b[gi] ^ borrow[gi];
            assign borrow[gi + 1] = (~a[gi] & b[gi]) | (~(a[gi] ^ b[gi]) & borrow[gi]);
        end
    endgenerate

    assign bout = borrow[8];
endmodule

module seq_restoring_divider #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    seq_restoring_divider_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_reg;
    state_t           state_next;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] m_reg;
    logic [CNT_W-1:0] count_reg;
    logic [WIDTH-1:0] quotient_reg;
    logic [WIDTH-1:0] remainder_reg;
    logic             dbz_reg;

    logic             carry;
    logic [WIDTH-1:0] a_shift;
    logic [WIDTH-1:0] q_shift;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             ok;
    logic [WIDTH-1:0] a_next;
    logic [WIDTH-1:0] q_next;
    logic             last_iter;

    // {carry, a_shift, q_shift} = {A, Q} << 1
    assign carry   = a_reg[WIDTH-1];
    assign a_shift = {a_reg[WIDTH-2:0], q_reg[WIDTH-1]};
    assign q_shift = {q_reg[WIDTH-2:0], 1'b0};

    ripple_subtractor u_sub (
        .a    (a_shift),
        .b    (m_reg),
        .diff (diff),
        .bout (bout)
    );

    // A carried-out bit means the partial remainder exceeds any 8-bit divisor.
    assign ok        = carry | ~bout;
    assign a_next    = ok ? diff : a_shift;
    assign q_next    = {q_shift[WIDTH-1:1], ok};
    assign last_iter = (count_reg == CNT_W'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (bus.start) begin
                    state_next = (bus.divisor != '0) ? RUN : DONE;
                end
            end
            RUN: begin
                if (last_iter) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_reg         <= '0;
            q_reg         <= '0;
            m_reg         <= '0;
            count_reg     <= '0;
            quotient_reg  <= '0;
            remainder_reg <= '0;
            dbz_reg       <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.start) begin
                        if (bus.divisor != '0) begin
                            m_reg     <= bus.divisor;
                            a_reg     <= '0;
                            q_reg     <= bus.dividend;
                            count_reg <= CNT_W'(WIDTH);
                        end else begin
                            quotient_reg  <= '1;
                            remainder_reg <= bus.dividend;
                            dbz_reg       <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    a_reg     <= a_next;
                    q_reg     <= q_next;
                    count_reg <= count_reg - CNT_W'(1);
                    if (last_iter) begin
                        quotient_reg  <= q_next;
                        remainder_reg <= a_next;
                        dbz_reg       <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.quotient    = quotient_reg;
    assign bus.remainder   = remainder_reg;
    assign bus.div_by_zero = dbz_reg;
    assign bus.busy        = (state_reg == RUN);
    assign bus.done        = (state_reg == DONE);
endmodule
